video_scanout: RTL and testbench

Raster read-out engine for the 24-bit RGB screen buffer: walks the frame in row-major order, issues one-word reads on the buffer's read port, and delivers pixels on a valid/ready stream tagged with start-of-frame and end-of-line. It is the display-side consumer of the buffer the CPU-side video controller writes. A small prefetch FIFO decouples fixed-latency memory reads from output back-pressure.

---
 rtl/video_pkg.sv | 14 +
 rtl/video_scanout_fifo.sv | 34 +++
 rtl/video_scanout.sv | 104 ++++++++++
 tb/tb_video_scanout.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// video_pkg: shared pixel, FIFO-entry and state types plus default widths for video_scanout.
package video_pkg;
  typedef logic [23:0] pixel_t;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, GAP} scanout_state_t;
  typedef struct packed {
    logic   sof;
    logic   eol;
    pixel_t pixel;
  } fifo_entry_t;
  localparam int DEFAULT_WIDTH_BITS  = 8;
  localparam int DEFAULT_HEIGHT_BITS = 8;
  localparam int DEFAULT_FIFO_BITS   = 2;
  localparam int DEFAULT_GAP_CYCLES  = 16;
endpackage

// File: rtl/video_scanout_fifo.sv
// video_scanout_fifo: show-ahead synchronous FIFO with occupancy; push and pop may coincide at any fill level.
module video_scanout_fifo
  import video_pkg::*;
#(
  parameter int DEPTH_BITS = DEFAULT_FIFO_BITS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  fifo_entry_t         push_data,
  input  logic                pop,
  output fifo_entry_t         head,
  output logic                empty,
  output logic [DEPTH_BITS:0] occupancy
);
  localparam int PW = DEPTH_BITS;
  localparam int OW = DEPTH_BITS + 1;
  fifo_entry_t mem [1 << DEPTH_BITS];
  logic [DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  assign empty = occupancy == '0;
  assign head  = mem[rd_ptr];
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= push_data;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      wr_ptr    <= wr_ptr + PW'(push);
      rd_ptr    <= rd_ptr + PW'(pop);
      occupancy <= occupancy + OW'(push) - OW'(pop);
    end
endmodule

// File: rtl/video_scanout.sv
// video_scanout: row-major read-out of the RGB screen buffer onto a valid/ready pixel stream with sof/eol tags.
// Define VIDEO_SCANOUT_FRAME_COUNT_EN to add the frame_count output.
module video_scanout
  import video_pkg::*;
#(
  parameter int SCREEN_WIDTH_BIT_WIDTH  = DEFAULT_WIDTH_BITS,
  parameter int SCREEN_HEIGHT_BIT_WIDTH = DEFAULT_HEIGHT_BITS,
  parameter int FIFO_DEPTH_BIT_WIDTH    = DEFAULT_FIFO_BITS,
  parameter int FRAME_GAP_CYCLES        = DEFAULT_GAP_CYCLES
) (
  input  logic                                                clock,
  input  logic                                                reset,
  input  logic                                                enable,
  output logic                                                mem_read,
  output logic [SCREEN_WIDTH_BIT_WIDTH+SCREEN_HEIGHT_BIT_WIDTH-1:0] mem_address,
  input  logic [23:0]                                         mem_data,
  output logic                                                pixel_valid,
  input  logic                                                pixel_ready,
  output logic [23:0]                                         pixel_data,
  output logic                                                pixel_sof,
  output logic                                                pixel_eol,
  output logic                                                frame_done,
  output logic                                                busy
`ifdef VIDEO_SCANOUT_FRAME_COUNT_EN
  ,
  output logic [15:0]                                         frame_count
`endif
);
  localparam int WB = SCREEN_WIDTH_BIT_WIDTH;
  localparam int HB = SCREEN_HEIGHT_BIT_WIDTH;
  localparam int FB = FIFO_DEPTH_BIT_WIDTH;
  localparam int CW = FB + 2;
  localparam logic [CW-1:0] DEPTH = CW'(1 << FB);
  localparam logic [15:0] GAP_LAST = 16'(FRAME_GAP_CYCLES);
  scanout_state_t state;
  logic [WB-1:0] x;
  logic [HB-1:0] y;
  logic [15:0] gap_cnt;
  logic in_flight, sof_q, eol_q, empty, pop;
  logic [FB:0] occupancy;
  logic [CW-1:0] credit_used;
  fifo_entry_t head;
  // Credits count buffered entries plus the read whose data lands this cycle.
  assign credit_used = CW'(occupancy) + CW'(in_flight);
  assign mem_read    = state == FETCH && credit_used < DEPTH;
  assign mem_address = {y, x};
  assign busy        = state != IDLE;
  assign pixel_valid = !empty;
  assign pop         = pixel_valid && pixel_ready;
  assign pixel_data  = pixel_valid ? head.pixel : '0;
  assign pixel_sof   = pixel_valid && head.sof;
  assign pixel_eol   = pixel_valid && head.eol;
  video_scanout_fifo #(.DEPTH_BITS(FB)) fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (in_flight),
    .push_data ('{sof: sof_q, eol: eol_q, pixel: mem_data}),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .occupancy (occupancy)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      gap_cnt    <= '0;
      in_flight  <= 1'b0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      in_flight  <= mem_read;
      sof_q      <= mem_read && x == '0 && y == '0;
      eol_q      <= mem_read && &x;
      frame_done <= 1'b0;
      if (mem_read) begin
        x <= x + WB'(1);
        if (&x) y <= y + HB'(1);
      end
      case (state)
        IDLE:  if (enable) begin
                 state <= FETCH;
                 x     <= '0;
                 y     <= '0;
               end
        FETCH: if (mem_read && &{y, x}) state <= DRAIN;
        DRAIN: if (pop && occupancy == (FB + 1)'(1) && !in_flight) begin
                 frame_done <= 1'b1;
                 gap_cnt    <= '0;
                 state      <= GAP;
               end
        GAP:   if (gap_cnt == GAP_LAST) state <= enable ? FETCH : IDLE;
               else gap_cnt <= gap_cnt + 16'd1;
        default: state <= IDLE;
      endcase
    end
`ifdef VIDEO_SCANOUT_FRAME_COUNT_EN
  always_ff @(posedge clock or negedge reset)
    if (!reset) frame_count <= '0;
    else frame_count <= frame_count + 16'(frame_done);
`endif
endmodule

// File: tb/tb_video_scanout.sv
// tb_video_scanout: directed vectors and corner sequences on a 4x2 frame; u0 has gap 0, u1 has gap 5.
module tb_video_scanout;
  import video_pkg::*;
  typedef struct packed {
    logic en, rdy, mr;
    logic [2:0] addr;
    logic v;
    logic [23:0] d;
    logic sof, eol, done, busy;
  } vec_t;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset0 = 1'b0, en0 = 1'b0, rdy0 = 1'b0;
  logic reset1 = 1'b0, en1 = 1'b0, rdy1 = 1'b0;
  logic mr0, v0, sof0, eol0, done0, busy0;
  logic mr1, v1, sof1, eol1, done1, busy1;
  logic [2:0] a0, a1;
  logic [23:0] d0, d1;
  logic [23:0] md0 = '0, md1 = '0;
  logic [15:0] fc0, fc1;
  int n_cmp = 0, n_err = 0, reads0 = 0;
  logic [25:0] q0[$];
  vec_t tbl[13];

  video_scanout #(.SCREEN_WIDTH_BIT_WIDTH(2), .SCREEN_HEIGHT_BIT_WIDTH(1),
                  .FIFO_DEPTH_BIT_WIDTH(2), .FRAME_GAP_CYCLES(0)) u0 (
    .clock(clock), .reset(reset0), .enable(en0), .mem_read(mr0), .mem_address(a0),
    .mem_data(md0), .pixel_valid(v0), .pixel_ready(rdy0), .pixel_data(d0),
    .pixel_sof(sof0), .pixel_eol(eol0), .frame_done(done0), .busy(busy0)
`ifdef VIDEO_SCANOUT_FRAME_COUNT_EN
    , .frame_count(fc0)
`endif
  );
  video_scanout #(.SCREEN_WIDTH_BIT_WIDTH(2), .SCREEN_HEIGHT_BIT_WIDTH(1),
                  .FIFO_DEPTH_BIT_WIDTH(2), .FRAME_GAP_CYCLES(5)) u1 (
    .clock(clock), .reset(reset1), .enable(en1), .mem_read(mr1), .mem_address(a1),
    .mem_data(md1), .pixel_valid(v1), .pixel_ready(rdy1), .pixel_data(d1),
    .pixel_sof(sof1), .pixel_eol(eol1), .frame_done(done1), .busy(busy1)
`ifdef VIDEO_SCANOUT_FRAME_COUNT_EN
    , .frame_count(fc1)
`endif
  );

  // Screen buffer model: word at address a holds 0x100 + a, one-cycle read latency.
  always @(posedge clock) begin
    md0 <= 24'h100 + 24'(a0);
    md1 <= 24'h100 + 24'(a1);
  end

  function automatic vec_t mk(input int en, rdy, mr, addr, v, d, sof, eol, done, busy);
    return '{1'(en), 1'(rdy), 1'(mr), 3'(addr), 1'(v), 24'(d), 1'(sof), 1'(eol), 1'(done), 1'(busy)};
  endfunction

  function automatic logic [32:0] obs0();
    return {mr0, a0, v0, d0, sof0, eol0, done0, busy0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    if (v0 && rdy0) q0.push_back({sof0, eol0, d0});
    if (mr0) reads0++;
    @(negedge clock);
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (!done0 && n < limit) begin tick(); n++; end
    chk({name, " frame_done"}, 64'(done0), 64'(1));
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (busy0 && n < limit) begin tick(); n++; end
    chk({name, " idle"}, 64'(busy0), 64'(0));
  endtask

  task automatic check_frames(input string name, input int nframes);
    chk({name, " count"}, 64'(q0.size()), 64'(8 * nframes));
    for (int i = 0; i < q0.size() && i < 8 * nframes; i++)
      chk($sformatf("%s px%0d", name, i), 64'(q0[i]),
          64'({i % 8 == 0, i % 8 == 3 || i % 8 == 7, 24'h100 + 24'(i % 8)}));
  endtask

  initial begin
    tbl[0]  = mk(1, 1, 0, 0, 0, 0,     0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 1, 0, 0, 0,     0, 0, 0, 1);
    tbl[2]  = mk(1, 1, 1, 1, 0, 0,     0, 0, 0, 1);
    tbl[3]  = mk(1, 1, 1, 2, 1, 'h100, 1, 0, 0, 1);
    tbl[4]  = mk(1, 1, 1, 3, 1, 'h101, 0, 0, 0, 1);
    tbl[5]  = mk(1, 1, 1, 4, 1, 'h102, 0, 0, 0, 1);
    tbl[6]  = mk(1, 1, 1, 5, 1, 'h103, 0, 1, 0, 1);
    tbl[7]  = mk(1, 1, 1, 6, 1, 'h104, 0, 0, 0, 1);
    tbl[8]  = mk(1, 1, 1, 7, 1, 'h105, 0, 0, 0, 1);
    tbl[9]  = mk(1, 1, 0, 0, 1, 'h106, 0, 0, 0, 1);
    tbl[10] = mk(1, 1, 0, 0, 1, 'h107, 0, 1, 0, 1);
    tbl[11] = mk(1, 1, 0, 0, 0, 0,     0, 0, 1, 1);
    tbl[12] = mk(0, 1, 1, 0, 0, 0,     0, 0, 0, 1);

    repeat (3) @(negedge clock);
    chk("reset u0", 64'(obs0()), 64'(0));
    chk("reset u1", 64'({mr1, a1, v1, d1, sof1, eol1, done1, busy1}), 64'(0));
    reset0 = 1'b1;
    tick();

    // Frame 1 cycle by cycle, enable kept high into the gap so frame 2 starts back-to-back.
    for (int k = 0; k < 13; k++) begin
      en0  = tbl[k].en;
      rdy0 = tbl[k].rdy;
      chk($sformatf("vec%0d", k), 64'(obs0()),
          64'({tbl[k].mr, tbl[k].addr, tbl[k].v, tbl[k].d, tbl[k].sof, tbl[k].eol, tbl[k].done, tbl[k].busy}));
      tick();
    end
    wait_idle("two frames", 40);
    check_frames("two frames", 2);

    // Enable dropped after the third pixel: frame completes, then back to IDLE.
    q0.delete();
    en0 = 1'b1; rdy0 = 1'b1;
    for (int n = 0; n < 20 && q0.size() < 3; n++) tick();
    en0 = 1'b0;
    wait_done("en drop", 30);
    chk("en drop busy at done", 64'(busy0), 64'(1));
    tick();
    chk("en drop busy after gap", 64'(busy0), 64'(0));
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("en drop quiet%0d", n), 64'({mr0, v0}), 64'(0));
      tick();
    end
    check_frames("en drop", 1);

    // Back-pressure: ready low for 10 cycles once the first pixel shows.
    q0.delete();
    reads0 = 0;
    en0 = 1'b1; rdy0 = 1'b0;
    for (int n = 0; n < 10 && !v0; n++) tick();
    en0 = 1'b0;
    for (int n = 0; n < 10; n++) begin
      chk($sformatf("hold%0d", n), 64'({v0, sof0, eol0, d0}), 64'({3'b110, 24'h100}));
      chk($sformatf("outstanding%0d", n), 64'(reads0 <= 4), 64'(1));
      tick();
    end
    chk("reads while stalled", 64'(reads0), 64'(4));
    rdy0 = 1'b1;
    wait_done("stall", 30);
    wait_idle("stall", 10);
    check_frames("stall", 1);
    chk("stall total reads", 64'(reads0), 64'(8));

    // Reset while three entries are buffered and one read is in flight.
    q0.delete();
    en0 = 1'b1; rdy0 = 1'b0;
    for (int n = 0; n < 10 && !v0; n++) tick();
    en0 = 1'b0;
    tick();
    tick();
    reset0 = 1'b0;
    #1;
    chk("async reset", 64'(obs0()), 64'(0));
    @(negedge clock);
    chk("reset held", 64'(obs0()), 64'(0));
    reset0 = 1'b1; rdy0 = 1'b1;
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("no stale%0d", n), 64'({mr0, v0, busy0}), 64'(0));
      tick();
    end
    en0 = 1'b1;
    tick();
    en0 = 1'b0;
    chk("restart addr0", 64'({mr0, a0}), 64'({1'b1, 3'd0}));
    wait_done("restart", 30);
    wait_idle("restart", 10);
    check_frames("restart", 1);

    // Gap of 5 on u1: five idle cycles between frame_done and the next read at address 0.
    reset1 = 1'b1; en1 = 1'b1; rdy1 = 1'b1;
    begin
      int n = 0;
      for (int k = 0; k < 40 && !done1; k++) tick();
      chk("gap5 frame_done", 64'(done1), 64'(1));
      tick();
      while (!mr1 && n < 20) begin n++; tick(); end
      chk("gap5 idle cycles", 64'(n), 64'(5));
      chk("gap5 restart addr", 64'({mr1, a1}), 64'({1'b1, 3'd0}));
    end
    en1 = 1'b0;

`ifdef VIDEO_SCANOUT_FRAME_COUNT_EN
    reset0 = 1'b0;
    @(negedge clock);
    reset0 = 1'b1;
    chk("frame_count reset", 64'(fc0), 64'(0));
    begin
      int frames = 0;
      en0 = 1'b1; rdy0 = 1'b1;
      for (int k = 0; k < 100 && frames < 3; k++) begin
        if (done0) frames++;
        if (frames == 3) en0 = 1'b0;
        else tick();
      end
      tick();
      chk("frame_count", 64'(fc0), 64'(3));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
